// File: rtl/triagem_pkg.sv
// Shared constants for the sorting controller: material codes, FSM states and gate indices.
package triagem_pkg;

  localparam logic [1:0] MAT_UNKNOWN = 2'b00;
  localparam logic [1:0] MAT_PLASTIC = 2'b01;
  localparam logic [1:0] MAT_METAL   = 2'b10;
  localparam logic [1:0] MAT_PAPER   = 2'b11;

  localparam int unsigned GATE_PLASTIC = 0;
  localparam int unsigned GATE_METAL   = 1;
  localparam int unsigned GATE_PAPER   = 2;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSample    = 3'd1,
    StSort      = 3'd2,
    StReject    = 3'd3,
    StWaitClear = 3'd4
  } state_t;

  function automatic logic [2:0] gate_for(input logic [1:0] mat);
    logic [2:0] g;
    g = '0;
    case (mat)
      MAT_PLASTIC: g[GATE_PLASTIC] = 1'b1;
      MAT_METAL:   g[GATE_METAL]   = 1'b1;
      MAT_PAPER:   g[GATE_PAPER]   = 1'b1;
      default:     g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Unsigned up-counter that holds at its maximum value instead of wrapping.
module contador_saturado #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/controle_triagem.sv
// Sorting controller: classifies an item within the timeout window, opens a bin gate or
// rejects, keeps saturating tallies and owns the external timeout counter's clear.
module controle_triagem
  import triagem_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned MAT_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 item_present,
  input  logic                 sensor_valid,
  input  logic [MAT_WIDTH-1:0] material,
  input  logic                 timeout,
  output logic                 timer_clear,
  output logic [2:0]           gate,
  output logic                 reject,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cnt_plastic,
  output logic [CNT_WIDTH-1:0] cnt_metal,
  output logic [CNT_WIDTH-1:0] cnt_paper,
  output logic [CNT_WIDTH-1:0] cnt_reject
);

  state_t     state_q, state_d;
  logic [1:0] mat_q, mat_d;
  logic [2:0] gate_d;
  logic       reject_d, busy_d, timer_clear_d;

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    unique case (state_q)
      StIdle: begin
        if (item_present) state_d = StSample;
      end
      StSample: begin
        // A known code beats a simultaneous timeout or departure.
        if (sensor_valid && (material != MAT_UNKNOWN)) begin
          state_d = StSort;
          mat_d   = material;
        end else if (timeout || !item_present) begin
          state_d = StReject;
        end
      end
      StSort, StReject: state_d = StWaitClear;
      StWaitClear: begin
        if (!item_present) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are computed from the next state so the registers track the state register.
    timer_clear_d = (state_d == StIdle) || (state_d == StWaitClear);
    gate_d        = (state_d == StSort) ? gate_for(mat_d) : 3'b000;
    reject_d      = (state_d == StReject);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mat_q       <= MAT_UNKNOWN;
      timer_clear <= 1'b1;
      gate        <= 3'b000;
      reject      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mat_q       <= mat_d;
      timer_clear <= timer_clear_d;
      gate        <= gate_d;
      reject      <= reject_d;
      busy        <= busy_d;
    end
  end

  // Gate and reject are high for exactly the SORT/REJECT cycle, so they double as increments.
  contador_saturado #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_plastic (
    .clock (clock),
    .reset (reset),
    .inc   (gate[GATE_PLASTIC]),
    .value (cnt_plastic)
  );

  contador_saturado #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_metal (
    .clock (clock),
    .reset (reset),
    .inc   (gate[GATE_METAL]),
    .value (cnt_metal)
  );

  contador_saturado #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_paper (
    .clock (clock),
    .reset (reset),
    .inc   (gate[GATE_PAPER]),
    .value (cnt_paper)
  );

  contador_saturado #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_reject (
    .clock (clock),
    .reset (reset),
    .inc   (reject),
    .value (cnt_reject)
  );

endmodule
